shift_clock_scheduler: RTL
==========================

Name: shift_clock_scheduler

Overview:
- Sequences the tag's backscatter shift clock: generates a divided square wave on clock_out for a programmed number of periods, then stops cleanly.
- Replaces free-running divider instances with a start/stop-controlled, runtime-retunable divider, so the packet FSM can gate the shift clock per ZigBee symbol burst.
- Sits between the packet sequencer (requester) and the backscatter modulator (consumer of clock_out / rise_tick).

Parameters:
- CNT_W, 12, width of half-period counter and half-period configuration.
- LEN_W, 16, width of period-count (burst length) input.
- DEFAULT_HALF, 12'h018, half-period value loaded at reset (25 input cycles per phase).

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst (sampled in IDLE only).
- stop  input  1  one-cycle abort request (sampled in RUN only).
- div_half  input  CNT_W  half-period minus 1, latched on accepted start.
- burst_len  input  LEN_W  number of full output periods, latched on accepted start.
- cfg_load  input  1  one-cycle retune strobe (RUN only).
- cfg_half  input  CNT_W  new half-period minus 1, captured with cfg_load.
- clock_out  output  1  divided clock, registered, glitch-free.
- rise_tick  output  1  high exactly in the cycle clock_out becomes 1.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse at burst end (normal or aborted).
- aborted  output  1  one-cycle pulse coincident with done when ended by stop.

Behaviour:
- Reset: state=IDLE, clock_out=0, rise_tick=0, busy=0, done=0, aborted=0, counter=0, half_q=DEFAULT_HALF, pending flags cleared, remaining=0. Reset mid-burst aborts immediately; done is not pulsed.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- IDLE, start=1, burst_len!=0:
  - half_q<=div_half, remaining<=burst_len, counter<=0, state<=RUN.
  - busy rises next cycle.
- IDLE, start=1, burst_len==0: stay IDLE; done=1 next cycle, aborted=0.
- IDLE: stop and cfg_load are ignored. If start and stop arrive together, start wins.
- RUN counter:
  - counter increments each cycle.
  - When counter==half_q: counter<=0 and clock_out toggles.
  - Each phase therefore lasts half_q+1 cycles; period = 2*(half_q+1). half_q=0 gives a divide-by-2 output.
- Burst timing:
  - First rising edge of clock_out is half_q+1 cycles after busy rises.
  - The low-to-high toggle asserts rise_tick in the same registered cycle.
  - The high-to-low toggle ends a period and decrements remaining.
- Normal termination:
  - Applies at the falling toggle where remaining==1.
  - In that same registered cycle: clock_out=0, state=IDLE, busy=0, done=1, counter=0.
- Retune:
  - cfg_load in RUN stores cfg_half into pend_half and sets pend_valid.
  - pend_half is applied to half_q only at a falling toggle (period boundary), so no runt phase occurs.
  - A second cfg_load before that boundary overwrites pend_half (last wins).
  - pend_valid is cleared at application or on return to IDLE.
- Stop:
  - stop in RUN with clock_out=0: next cycle go IDLE, done=1, aborted=1. A partial low phase is acceptable.
  - stop in RUN with clock_out=1: set stop_pend; the high phase completes normally.
  - At the falling toggle: IDLE, done=1, aborted=1.
  - If stop_pend and the last period coincide, aborted=1 (stop takes precedence).
- start in RUN is ignored; no queuing.
- Width rules:
  - counter compare is equality at CNT_W bits.
  - remaining is an LEN_W-bit decrement and never wraps, because termination occurs at value 1.

Decomposition:
- Shared package shift_clk_pkg contains:
  - state enum {IDLE, RUN};
  - DEFAULT_HALF constant;
  - CNT_W and LEN_W defaults.
- One sub-module: half_period_counter (counter, terminal compare, clear input, tc output). The scheduler owns clock_out, the FSM, retune and stop logic.

Test Plan:
- start, div_half=12'h018, burst_len=3 -> 3 periods of 25 high / 25 low; busy high for 150 cycles; done in the same cycle as the final fall; 3 rise_tick pulses; aborted=0.
- start, div_half=0, burst_len=4 -> clock_out toggles every cycle for 8 cycles; done with the 4th fall.
- div_half=4, burst_len=4; cfg_load cfg_half=9 during the first high phase -> period 1 is 5/5; periods 2–4 are 10/10.
- div_half=7, burst_len=10:
  - stop at cycle 3 of a high phase -> high completes at 8 cycles, then done+aborted with clock_out=0;
  - a repeat run with stop during a low phase -> done+aborted next cycle.
- start with burst_len=0 -> busy stays 0; done=1 one cycle later; clock_out stays 0.
- reset asserted mid-burst (clock_out=1) -> next cycle all outputs are 0 and no done; a new start afterwards runs with half_q=div_half normally.

Source files
------------

// File: rtl/shift_clk_pkg.sv
// Shared types and default sizing for the backscatter shift-clock scheduler.
package shift_clk_pkg;

    localparam int unsigned CNT_W_DEFAULT = 12;
    localparam int unsigned LEN_W_DEFAULT = 16;

    // Reset half-period: 25 input cycles per output phase.
    localparam logic [CNT_W_DEFAULT-1:0] DEFAULT_HALF_RST = 12'h018;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_clock_scheduler_half_period_counter.sv
// Half-period counter: counts up to the programmed half value, flags terminal count, wraps to zero.
module half_period_counter #(
    parameter int unsigned CNT_W = shift_clk_pkg::CNT_W_DEFAULT
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] half,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    assign tc_c = en && (count == half);

    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_clock_scheduler.sv
// Start/stop controlled, runtime-retunable shift-clock divider for per-burst backscatter gating.
module shift_clock_scheduler
    import shift_clk_pkg::*;
#(
    parameter int unsigned      CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned      LEN_W        = LEN_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_RST)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] div_half,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clock_out,
    output logic             rise_tick,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_e           state;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;
    logic             stop_pend;
    logic [LEN_W-1:0] remaining;

    logic run_c;
    logic tc_c;
    logic rise_c;
    logic fall_c;
    logic stop_req_c;
    logic abort_low_c;
    logic finish_c;
    logic clear_c;

    // Phase-edge decode; a fall always closes a full period.
    assign run_c       = (state == RUN);
    assign rise_c      = tc_c && !clock_out;
    assign fall_c      = tc_c && clock_out;
    assign stop_req_c  = stop_pend || stop;
    assign abort_low_c = run_c && stop && !clock_out;
    assign finish_c    = fall_c && (stop_req_c || (remaining == LEN_W'(1)));
    assign clear_c     = !run_c || abort_low_c || finish_c;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .clock_in (clock_in),
        .reset    (reset),
        .en       (run_c),
        .clear    (clear_c),
        .half     (half_q),
        .tc_c     (tc_c)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= IDLE;
            clock_out  <= 1'b0;
            rise_tick  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            half_q     <= DEFAULT_HALF;
            pend_half  <= '0;
            pend_valid <= 1'b0;
            stop_pend  <= 1'b0;
            remaining  <= '0;
        end else begin
            rise_tick <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            half_q    <= div_half;
                            remaining <= burst_len;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cfg_load) begin
                        pend_half  <= cfg_half;
                        pend_valid <= 1'b1;
                    end
                    // Exit paths override any retune captured in the same cycle.
                    if (abort_low_c || finish_c) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clock_out  <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= abort_low_c || stop_req_c;
                        pend_valid <= 1'b0;
                        stop_pend  <= 1'b0;
                    end else if (rise_c) begin
                        clock_out <= 1'b1;
                        rise_tick <= 1'b1;
                    end else if (fall_c) begin
                        clock_out  <= 1'b0;
                        remaining  <= remaining - LEN_W'(1);
                        if (pend_valid) begin
                            half_q <= pend_half;
                        end
                        pend_valid <= cfg_load;
                    end else if (stop && clock_out) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
